// File: rtl/multicycle_ctrl_if.sv
// Control-side bundle of the multicycle MIPS controller.
//
// Handshake: mem_req is a request level that stays high for as long as the
// controller sits in a memory state (FETCH, MEMRD, MEMWR). The access completes
// in the cycle where mem_req && mem_ready are both 1 at the rising edge. If
// mem_ready stays low for MAX_WAIT cycles the controller aborts (mem_timeout)
// and drops the request by returning to FETCH. memwrite is meaningful only
// while mem_req is high.
//
// Modports:
//   master - the controller: reads op/mem_ready, drives all control outputs.
//   slave  - the datapath/memory side: the mirror image.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_o;

  modport master (
    input  op, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regwrite, regdst, memtoreg,
           instr_done, illegal_op, mem_timeout, state_o
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regwrite, regdst, memtoreg,
           instr_done, illegal_op, mem_timeout, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM sequencing a shared datapath
// (PC, IR, register file, ALU, unified memory) over 3-5 cycles per
// instruction for R-type, LW, SW, BEQ, ADDI and J, with a memory wait-state
// handshake and timeout.
//
// Ports:
//   clk      - core clock, all state on the rising edge
//   reset_n  - synchronous active-low reset
//   bus      - multicycle_ctrl_if.master: op/mem_ready in, control out,
//              state_o exposes the current FSM state for debug
module multicycle_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_st;
  logic               timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // The cycle holding cnt == MAX_WAIT-1 with no ready is the MAX_WAIT-th
    // wait cycle, so it is the one that aborts.
    timeout = wait_st && !bus.mem_ready && (cnt_q == CNT_W'(MAX_WAIT - 1));

    state_d         = state_q;
    bus.mem_req     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.iord        = 1'b0;
    bus.irwrite     = 1'b0;
    bus.pcwrite     = 1'b0;
    bus.branch      = 1'b0;
    bus.pcsrc       = 2'b00;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.aluop       = 2'b00;
    bus.regwrite    = 1'b0;
    bus.regdst      = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = timeout;

    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = 2'b01;
        // An abort stays in FETCH, so the same PC is refetched.
        if (!timeout && bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          6'b000000:           state_d = RTYPEEX;
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000100:           state_d = BEQEX;
          6'b001000:           state_d = ADDIEX;
          6'b000010:           state_d = JEX;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (timeout)            state_d = FETCH;
        else if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.regwrite   = 1'b1;
        bus.memtoreg   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (timeout) begin
          state_d = FETCH;
        end else if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        state_d     = RTYPEWB;
      end
      RTYPEWB: begin
        bus.regwrite   = 1'b1;
        bus.regdst     = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      BEQEX: begin
        bus.alusrca    = 1'b1;
        bus.aluop      = 2'b01;
        bus.branch     = 1'b1;
        bus.pcsrc      = 2'b01;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      JEX: begin
        bus.pcwrite    = 1'b1;
        bus.pcsrc      = 2'b10;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      // Unused codes 12-15: all enables low, recover to FETCH.
      default: state_d = FETCH;
    endcase

    // Counter runs only while a memory state keeps waiting; any ready,
    // abort or state change clears it.
    cnt_d = (wait_st && !bus.mem_ready && !timeout) ? cnt_q + 1'b1 : '0;

    // Reset must silence side effects in the same cycle, even mid-access.
    if (!reset_n) begin
      bus.pcwrite     = 1'b0;
      bus.irwrite     = 1'b0;
      bus.branch      = 1'b0;
      bus.regwrite    = 1'b0;
      bus.mem_req     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.instr_done  = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;
    end
  end

  assign bus.state_o = state_q;

endmodule
